// File: rtl/card_deal_scheduler.sv
// card_deal_scheduler
// Sequences card deliveries from a shared card source to three hands
// (player, split, dealer). A round opens with a fixed four-card deal;
// further cards are granted round-robin among the hands that ask for one.
// Illegal card values from the source are dropped and the fetch retried.
module card_deal_scheduler #(
    parameter int MAX_CARDS = 4,
    parameter int RR_INIT   = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       deal_start,
    input  logic       req_player,
    input  logic       req_split,
    input  logic       req_dealer,
    output logic       src_req,
    input  logic       src_valid,
    input  logic [3:0] src_card,
    output logic [3:0] card_out,
    output logic [1:0] card_dest,
    output logic       card_strobe,
    output logic [2:0] player_cnt,
    output logic [2:0] split_cnt,
    output logic [2:0] dealer_cnt,
    output logic       busy,
    output logic       overflow
);

    localparam logic [2:0] CNT_MAX     = 3'(MAX_CARDS);
    localparam logic [1:0] PTR_INIT    = 2'(RR_INIT);
    localparam logic [1:0] HAND_PLAYER = 2'd0;
    localparam logic [1:0] HAND_SPLIT  = 2'd1;
    localparam logic [1:0] HAND_DEALER = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_INIT    = 3'd1,
        S_ARB     = 3'd2,
        S_FETCH   = 3'd3,
        S_DELIVER = 3'd4
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] slot_q, slot_d;
    logic       in_init_q, in_init_d;
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] dest_q, dest_d;
    logic [3:0] card_q, card_d;
    logic [2:0] player_cnt_q, player_cnt_d;
    logic [2:0] split_cnt_q, split_cnt_d;
    logic [2:0] dealer_cnt_q, dealer_cnt_d;
    logic       split_dealt_q, split_dealt_d;
    logic [1:0] ovf_cnt_q, ovf_cnt_d;

    // Arbitration helpers; bit 3 is a permanently empty pad so that any
    // 2-bit hand index stays inside the vectors.
    logic [3:0] req_act;
    logic [3:0] hand_full;
    logic [3:0] req_elig;
    logic       split_ok;
    logic       grant_vld;
    logic [1:0] grant_idx;
    logic       ovf_cond;
    logic       card_legal;

    // Count increment that sticks at the hand limit instead of wrapping.
    function automatic logic [2:0] sat_inc(input logic [2:0] cnt);
        return (cnt >= CNT_MAX) ? cnt : cnt + 3'd1;
    endfunction

    // Next hand in round-robin order player -> split -> dealer -> player.
    function automatic logic [1:0] rr_next(input logic [1:0] hand);
        return (hand >= HAND_DEALER) ? HAND_PLAYER : hand + 2'd1;
    endfunction

    assign split_ok   = (split_cnt_q != 3'd0) || split_dealt_q;
    assign card_legal = (src_card >= 4'd1) && (src_card <= 4'd10);

    // Round-robin grant among requesting hands that still have room.
    always_comb begin
        logic [1:0] cand;
        req_act   = {1'b0, req_dealer, req_split & split_ok, req_player};
        hand_full = {1'b0, dealer_cnt_q >= CNT_MAX, split_cnt_q >= CNT_MAX,
                     player_cnt_q >= CNT_MAX};
        req_elig  = req_act & ~hand_full;
        grant_vld = 1'b0;
        grant_idx = ptr_q;
        cand      = rr_next(ptr_q);
        for (int i = 0; i < 3; i++) begin
            if (!grant_vld && req_elig[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
            cand = rr_next(cand);
        end
        // Someone is asking, but every asking hand is already full.
        ovf_cond = (|req_act) && !(|req_elig);
    end

    // State register and all datapath/control flops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            slot_q        <= 2'd0;
            in_init_q     <= 1'b0;
            ptr_q         <= PTR_INIT;
            dest_q        <= HAND_PLAYER;
            card_q        <= 4'd0;
            player_cnt_q  <= 3'd0;
            split_cnt_q   <= 3'd0;
            dealer_cnt_q  <= 3'd0;
            split_dealt_q <= 1'b0;
            ovf_cnt_q     <= 2'd0;
        end else begin
            state_q       <= state_d;
            slot_q        <= slot_d;
            in_init_q     <= in_init_d;
            ptr_q         <= ptr_d;
            dest_q        <= dest_d;
            card_q        <= card_d;
            player_cnt_q  <= player_cnt_d;
            split_cnt_q   <= split_cnt_d;
            dealer_cnt_q  <= dealer_cnt_d;
            split_dealt_q <= split_dealt_d;
            ovf_cnt_q     <= ovf_cnt_d;
        end
    end

    // Next-state and next-value logic for the dealing sequence.
    always_comb begin
        state_d       = state_q;
        slot_d        = slot_q;
        in_init_d     = in_init_q;
        ptr_d         = ptr_q;
        dest_d        = dest_q;
        card_d        = card_q;
        player_cnt_d  = player_cnt_q;
        split_cnt_d   = split_cnt_q;
        dealer_cnt_d  = dealer_cnt_q;
        split_dealt_d = split_dealt_q;

        // Overflow phase counter runs only while the blocked condition holds.
        ovf_cnt_d = ((state_q == S_ARB) && ovf_cond) ? ovf_cnt_q + 2'd1 : 2'd0;

        case (state_q)
            S_IDLE: begin
                if (deal_start) begin
                    player_cnt_d  = 3'd0;
                    split_cnt_d   = 3'd0;
                    dealer_cnt_d  = 3'd0;
                    split_dealt_d = 1'b0;
                    slot_d        = 2'd0;
                    in_init_d     = 1'b1;
                    state_d       = S_INIT;
                end
            end

            S_INIT: begin
                // Opening deal alternates player, dealer, player, dealer.
                dest_d  = slot_q[0] ? HAND_DEALER : HAND_PLAYER;
                ptr_d   = slot_q[0] ? HAND_DEALER : HAND_PLAYER;
                state_d = S_FETCH;
            end

            S_ARB: begin
                if (deal_start) begin
                    player_cnt_d  = 3'd0;
                    split_cnt_d   = 3'd0;
                    dealer_cnt_d  = 3'd0;
                    split_dealt_d = 1'b0;
                    slot_d        = 2'd0;
                    in_init_d     = 1'b1;
                    state_d       = S_INIT;
                end else if (grant_vld) begin
                    dest_d  = grant_idx;
                    ptr_d   = grant_idx;
                    state_d = S_FETCH;
                end
            end

            S_FETCH: begin
                // Illegal values are dropped and the request stays up.
                if (src_valid && card_legal) begin
                    card_d  = src_card;
                    state_d = S_DELIVER;
                end
            end

            S_DELIVER: begin
                case (dest_q)
                    HAND_PLAYER: player_cnt_d = sat_inc(player_cnt_q);
                    HAND_SPLIT: begin
                        split_cnt_d   = sat_inc(split_cnt_q);
                        split_dealt_d = 1'b1;
                    end
                    default:     dealer_cnt_d = sat_inc(dealer_cnt_q);
                endcase
                if (in_init_q && (slot_q != 2'd3)) begin
                    slot_d  = slot_q + 2'd1;
                    state_d = S_INIT;
                end else begin
                    in_init_d = 1'b0;
                    state_d   = S_ARB;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from the current state and registered values.
    always_comb begin
        src_req     = (state_q == S_FETCH);
        card_strobe = (state_q == S_DELIVER);
        busy        = (state_q != S_IDLE) && (state_q != S_ARB);
        overflow    = (state_q == S_ARB) && ovf_cond && (ovf_cnt_q == 2'd0);
        card_out    = card_q;
        card_dest   = dest_q;
        player_cnt  = player_cnt_q;
        split_cnt   = split_cnt_q;
        dealer_cnt  = dealer_cnt_q;
    end

endmodule

// File: doc/card_deal_scheduler.md
CARD_DEAL_SCHEDULER -- requirements
Module: card_deal_scheduler

Interface
REQ-001 The block SHALL expose parameter MAX_CARDS, default 4, meaning the maximum number of cards per hand (range 2..7).
REQ-002 The block SHALL expose parameter RR_INIT, default 0, meaning the round-robin pointer value after reset (0 player, 1 split, 2 dealer).
REQ-003 clk  input  1  single system clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; the block is in reset while reset=0.
REQ-005 deal_start  input  1  pulse; starts a round with the initial four-card deal.
REQ-006 req_player, req_split, req_dealer  input  1 each  level requests for one card to that hand.
REQ-007 src_req  output  1  request to the card source.
REQ-008 src_valid  input  1  card source presents a card on src_card.
REQ-009 src_card  input  4  card value; legal values are 1..10.
REQ-010 card_out  output  4  delivered card value.
REQ-011 card_dest  output  2  destination of card_out: 00 player, 01 split, 10 dealer.
REQ-012 card_strobe  output  1  one-cycle pulse qualifying card_out and card_dest.
REQ-013 player_cnt, split_cnt, dealer_cnt  output  3 each  cards delivered to each hand this round.
REQ-014 busy  output  1  high in every state except IDLE and ARB.
REQ-015 overflow  output  1  one-cycle pulse when a request targets a full hand.

Function
REQ-016 The FSM SHALL have the states IDLE, INIT, ARB, FETCH and DELIVER.
REQ-017 IDLE: when deal_start=1, the block SHALL clear all counts and go to INIT with slot index 0; otherwise it stays in IDLE.
REQ-018 INIT SHALL deal four cards in slot order player, dealer, player, dealer, each through FETCH/DELIVER, with req_* inputs ignored.
REQ-019 After the fourth DELIVER, the block SHALL go to ARB.
REQ-020 ARB SHALL grant among active requests, with priority starting at the hand after the last grantee (player -> split -> dealer -> player), then go to FETCH.
REQ-021 ARB SHALL treat req_split as inactive while split_cnt=0 and no split has been dealt.
REQ-022 The pointer SHALL advance only on an actual grant.
REQ-023 ARB with no active request SHALL remain in ARB.
REQ-024 deal_start in ARB SHALL end the round: counts cleared, state INIT.
REQ-025 FETCH SHALL hold src_req=1 until a cycle with src_valid=1, with no timeout.
REQ-026 On that cycle, src_card SHALL be captured and src_req SHALL drop on the next edge.
REQ-027 A captured src_card of 0 or 11..15 SHALL be discarded and src_req SHALL stay asserted; no strobe and no count change result.
REQ-028 DELIVER SHALL assert card_strobe for exactly one cycle with registered card_out and card_dest.
REQ-029 DELIVER SHALL increment the destination count on the same edge, then return to INIT (slots remaining) or ARB.
REQ-030 Latency SHALL be: src_valid with a legal card at edge N, then card_strobe high in cycle N+1.
REQ-031 A request to a hand with count=MAX_CARDS SHALL NOT be granted.
REQ-032 If that full-hand request is the only active request in ARB, overflow SHALL pulse one cycle and the state SHALL stay ARB.
REQ-033 overflow SHALL re-pulse every 4th cycle while the condition persists.
REQ-034 Counts SHALL saturate at MAX_CARDS and never wrap.
REQ-035 deal_start during INIT, FETCH or DELIVER SHALL be ignored.
REQ-036 Simultaneous req_* with src_valid outside FETCH SHALL have no effect.

Reset
REQ-037 reset=0 SHALL immediately force: state IDLE, src_req=0, card_strobe=0, overflow=0, card_out=0, card_dest=00, all counts=0, busy=0, pointer=RR_INIT.
REQ-038 Reset asserted mid-FETCH or mid-DELIVER SHALL abort the card with no strobe after release.
REQ-039 Operation SHALL resume only on the first rising clk edge after reset returns to 1.

Verification
REQ-040 Initial deal: deal_start, source returns 7,3,10,1 with src_valid one cycle after each src_req -> strobes with dest 00,10,00,10; player_cnt=2; dealer_cnt=2; state ARB.
REQ-041 Round-robin: req_player and req_dealer held high after the initial deal, last grantee dealer -> grants alternate player, dealer, player; player_cnt reaches MAX_CARDS=4.
REQ-042 Overflow: player_cnt=4, only req_player high -> no src_req; overflow pulses at cycles 0, 4 and 8; counts unchanged.
REQ-043 Illegal card: src_card=0 then 12 then 5 on consecutive src_valid cycles -> single strobe with card_out=5; src_req continuous until the 5 is taken.
REQ-044 Reset mid-operation: reset=0 while src_req=1 -> src_req=0 asynchronously; no strobe after release; all counts 0; state IDLE.
REQ-045 Ignored restart: deal_start pulsed during INIT slot 2 -> deal completes normally with four strobes only.
